// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// Optional feature macro used by the arbiter: MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

  // Arbiter FSM states: idle or granted to one of the two masters.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2
  } arb_state_e;

  // Owner encoding used for round-robin bookkeeping.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // Read data returned to the owner when a grant is aborted by the timeout.
  localparam logic [31:0] ABORT_RDATA = 32'hDEAD_BEEF;

  // Width of the grant-timeout counter; covers the full TIMEOUT_CYCLES range.
  localparam int unsigned TMR_W = 10;

endpackage

// File: rtl/mem_arb_timer.sv
// Grant timeout counter for mem_arbiter.
// Only exists when MEM_ARB_TIMEOUT_EN is defined; the default build has no timer.
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,   // a new grant begins this cycle
  input  logic wait_i,    // grant active with mem_ready low
  output logic expire_o   // wait has lasted long enough: abort now
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  // Counter next state: clear at grant start, count stalled grant cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = {TMR_W{1'b0}};
    end else if (wait_i) begin
      cnt_d = cnt_q + {{(TMR_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= {TMR_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = wait_i && (cnt_q == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch
// and data load/store. Define MEM_ARB_TIMEOUT_EN to add a grant timeout
// that aborts a stalled access with ABORT_RDATA and sets timeout_err.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        timeout_err
);

  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 1023)) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be in 2..1023");
  end

  arb_state_e  state_q, state_d;
  owner_e      last_q, last_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;

  logic        expire_s;
  logic        done_s;
  logic [31:0] rd_s;

  // A grant finishes on mem_ready or on timeout expiry.
  assign done_s = (state_q != IDLE) && (mem_ready || expire_s);
  assign rd_s   = mem_ready ? mem_rdata : ABORT_RDATA;

  // Next-state logic: round-robin grant from IDLE, return to IDLE on completion.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (if_req && (!d_req || (last_q == OWN_D))) begin
          state_d = GNT_IF;
          last_d  = OWN_IF;
          addr_d  = if_addr;
          we_d    = 1'b0;
          wdata_d = 32'h0000_0000;
        end else if (d_req) begin
          state_d = GNT_D;
          last_d  = OWN_D;
          addr_d  = d_addr;
          we_d    = d_we;
          wdata_d = d_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      GNT_IF, GNT_D: begin
        if (done_s) begin
          // Clearing the latches keeps the memory port at zero while idle.
          state_d = IDLE;
          addr_d  = 32'h0000_0000;
          we_d    = 1'b0;
          wdata_d = 32'h0000_0000;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
        addr_d  = 32'h0000_0000;
        we_d    = 1'b0;
        wdata_d = 32'h0000_0000;
      end
    endcase
  end

  // State, round-robin owner and latched request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= OWN_D;
      addr_q  <= 32'h0000_0000;
      we_q    <= 1'b0;
      wdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  // Completion outputs: only the current owner ever sees ack or data.
  always_comb begin
    if_ack   = 1'b0;
    if_rdata = 32'h0000_0000;
    d_ack    = 1'b0;
    d_rdata  = 32'h0000_0000;
    case (state_q)
      GNT_IF: begin
        if_ack   = done_s;
        if_rdata = done_s ? rd_s : 32'h0000_0000;
      end
      GNT_D: begin
        d_ack    = done_s;
        d_rdata  = done_s ? rd_s : 32'h0000_0000;
      end
      default: begin
        if_ack   = 1'b0;
        d_ack    = 1'b0;
      end
    endcase
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_stall  = if_req && !if_ack;
  assign d_stall   = d_req && !d_ack;

`ifdef MEM_ARB_TIMEOUT_EN
  logic start_s;
  logic wait_s;
  logic terr_q;

  assign start_s = (state_q == IDLE) && (state_d != IDLE);
  assign wait_s  = (state_q != IDLE) && !mem_ready;

  mem_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_s),
    .wait_i   (wait_s),
    .expire_o (expire_s)
  );

  // Sticky abort flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      terr_q <= 1'b0;
    end else begin
      terr_q <= terr_q | expire_s;
    end
  end

  assign timeout_err = terr_q;
`else
  assign expire_s    = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// masters, all checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int TO = 4;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        if_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        timeout_err;

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ack(if_ack), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the access in flight (if any) and arbitration history.
  bit          m_busy;
  bit          m_own_d;
  bit          m_last_d;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  int          m_wait;
  bit          m_terr;

  bit last_if_ack, last_d_ack;
  int ack_log[$];
  int we_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit timed_out();
    return m_busy && !mem_ready && TO_EN && (m_wait == TO - 1);
  endfunction

  function automatic bit finishing();
    return m_busy && (mem_ready || timed_out());
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_own_d = 1'b0; m_last_d = 1'b1; m_we = 1'b0;
    m_addr = 32'h0; m_wdata = 32'h0; m_wait = 0; m_terr = 1'b0;
    last_if_ack = 1'b0; last_d_ack = 1'b0;
  endtask

  task automatic check_outputs();
    bit e_if, e_d;
    logic [31:0] e_rd;
    e_if = finishing() && !m_own_d;
    e_d  = finishing() && m_own_d;
    e_rd = mem_ready ? mem_rdata : 32'hDEAD_BEEF;
    chk("mem_req",   32'(mem_req),   32'(m_busy));
    chk("mem_we",    32'(mem_we),    m_busy ? 32'(m_we) : 32'h0);
    chk("mem_addr",  mem_addr,       m_busy ? m_addr : 32'h0);
    chk("mem_wdata", mem_wdata,      m_busy ? m_wdata : 32'h0);
    chk("if_ack",    32'(if_ack),    32'(e_if));
    chk("d_ack",     32'(d_ack),     32'(e_d));
    chk("if_rdata",  if_rdata,       e_if ? e_rd : 32'h0);
    if (!(e_d && m_we)) chk("d_rdata", d_rdata, e_d ? e_rd : 32'h0);
    chk("if_stall",  32'(if_stall),  32'(if_req && !e_if));
    chk("d_stall",   32'(d_stall),   32'(d_req && !e_d));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    last_if_ack = e_if;
    last_d_ack  = e_d;
    if (if_ack) ack_log.push_back(0);
    if (d_ack) ack_log.push_back(1);
    if (mem_we) we_cycles++;
  endtask

  task automatic model_step();
    if (!rst) begin
      model_reset();
    end else if (m_busy) begin
      if (finishing()) begin
        if (timed_out()) m_terr = 1'b1;
        m_busy = 1'b0;
      end else begin
        m_wait++;
      end
    end else if (if_req && (!d_req || m_last_d)) begin
      m_busy = 1'b1; m_own_d = 1'b0; m_last_d = 1'b0;
      m_addr = if_addr; m_we = 1'b0; m_wdata = 32'h0; m_wait = 0;
    end else if (d_req) begin
      m_busy = 1'b1; m_own_d = 1'b1; m_last_d = 1'b1;
      m_addr = d_addr; m_we = d_we; m_wdata = d_wdata; m_wait = 0;
    end
  endtask

  // One clock: check just after the falling edge, advance model at rising edge.
  task automatic cycle();
    #1 check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    rst = 1'b0;
    #1 model_reset();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drive_random();
    if (if_req && last_if_ack) if_req = 1'b0;
    if (d_req && last_d_ack) d_req = 1'b0;
    if (!if_req && ($urandom_range(0, 99) < 50)) begin
      if_req = 1'b1; if_addr = $urandom;
    end else if (if_req && ($urandom_range(0, 99) < 3)) begin
      if_req = 1'b0;
    end
    if (!d_req && ($urandom_range(0, 99) < 50)) begin
      d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
      d_addr = $urandom; d_wdata = $urandom;
    end else if (d_req && ($urandom_range(0, 99) < 3)) begin
      d_req = 1'b0;
    end
    mem_ready = ($urandom_range(0, 99) < 55);
    mem_rdata = $urandom;
  endtask

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0; mem_ready = 1'b0;
    we_cycles = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single fetch, memory ready in the first grant cycle.
    ack_log.delete();
    if_req = 1'b1; if_addr = 32'h0000_0100; mem_ready = 1'b0;
    cycle();
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    cycle();
    if_req = 1'b0; mem_ready = 1'b0;
    cycle();
    chk("fetch_ack_count", 32'(ack_log.size()), 32'd1);
    if (ack_log.size() > 0) chk("fetch_owner", 32'(ack_log[0]), 32'd0);

    // Both masters held: grants alternate starting with fetch.
    do_reset();
    ack_log.delete();
    if_req = 1'b1; if_addr = 32'h0000_0040;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3000; d_wdata = 32'h0;
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    repeat (8) cycle();
    chk("rr_ack_count", 32'(ack_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < ack_log.size()) chk("rr_order", 32'(ack_log[i]), 32'(i % 2));
    end

    // Store with three wait cycles.
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b1;
    d_addr = 32'h0000_2000; d_wdata = 32'hA5A5_A5A5; mem_ready = 1'b0;
    cycle();
    ack_log.delete(); we_cycles = 0;
    repeat (3) cycle();
    mem_ready = 1'b1;
    cycle();
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    cycle();
    chk("store_we_cycles", 32'(we_cycles), 32'd4);
    chk("store_ack_count", 32'(ack_log.size()), 32'd1);
    if (ack_log.size() > 0) chk("store_owner", 32'(ack_log[0]), 32'd1);

    // Reset in the middle of a data grant, then a contended grant.
    d_req = 1'b1; d_addr = 32'h0000_0800; mem_ready = 1'b0;
    cycle();
    cycle();
    ack_log.delete();
    do_reset();
    chk("rst_ack_count", 32'(ack_log.size()), 32'd0);
    if_req = 1'b1; if_addr = 32'h0000_0200; mem_ready = 1'b1;
    cycle();
    cycle();
    chk("rst_rr_count", 32'(ack_log.size()), 32'd1);
    if (ack_log.size() > 0) chk("rst_rr_owner", 32'(ack_log[0]), 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never ready: abort on the TO-th grant cycle, flag stays set.
    do_reset();
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0500; mem_ready = 1'b0;
    repeat (TO + 3) cycle();
    chk("timeout_flag", 32'(timeout_err), 32'd1);
    if_req = 1'b0;
    repeat (3) cycle();
    chk("timeout_sticky", 32'(timeout_err), 32'd1);
`endif

    // Randomized traffic with occasional resets.
    do_reset();
    if_req = 1'b0; d_req = 1'b0;
    repeat (800) begin
      drive_random();
      cycle();
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
